// File: rtl/bnn_dot_prod_cfu_initiator.sv
// BnnDotProdCfuInitiator: requester-side sequencer for the BNN dot-product CFU.
// Streams (activation, weight) word pairs into CFU requests, collects the
// per-word popcount responses, accumulates them and reports the dot product.
module bnn_dot_prod_cfu_initiator #(
  parameter int CFU_FUNCTION_ID_W = 1,
  parameter int CFU_REQ_DATA_W    = 32,
  parameter int CFU_RESP_DATA_W   = 32,
  parameter int MAX_WORDS         = 16,
  parameter int MAX_INFLIGHT      = 2,
  parameter int ACC_W             = 16
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                start,
  input  logic [$clog2(MAX_WORDS+1)-1:0]      n_words,
  output logic                                busy,
  output logic                                done,
  output logic [ACC_W-1:0]                    result,
  output logic [ACC_W:0]                      dot,
  input  logic                                op_valid,
  output logic                                op_ready,
  input  logic [CFU_REQ_DATA_W-1:0]           op_a,
  input  logic [CFU_REQ_DATA_W-1:0]           op_w,
  output logic                                req_valid,
  input  logic                                req_ready,
  output logic [CFU_FUNCTION_ID_W-1:0]        req_function_id,
  output logic [2*CFU_REQ_DATA_W-1:0]         req_data,
  input  logic                                resp_valid,
  output logic                                resp_ready,
  input  logic [CFU_RESP_DATA_W-1:0]          resp_data
);

  localparam int NW   = $clog2(MAX_WORDS + 1);
  localparam int IF_W = $clog2(MAX_INFLIGHT + 1);
  localparam int PC_W = $clog2(CFU_REQ_DATA_W) + 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  state_t            state_q, state_d;
  logic [NW-1:0]     n_q, n_d;
  logic [NW-1:0]     issued_q, issued_d;
  logic [NW-1:0]     received_q, received_d;
  logic [IF_W-1:0]   inflight_q, inflight_d;
  logic [ACC_W-1:0]  result_q, result_d;
  logic [ACC_W:0]    dot_q, dot_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              resp_ready_q, resp_ready_d;

  logic              canIssue;
  logic              reqFire;
  logic              respFire;
  logic              respAccept;
  logic [PC_W-1:0]   popCount;
  logic [ACC_W+1:0]  twiceResult;
  logic [ACC_W+1:0]  bitTotal;
  logic [ACC_W+1:0]  dotWide;
  logic              unusedRespBits;

  // Requests are a pure pass-through of the operand stream, gated by the
  // word budget and the number of outstanding responses; nothing is buffered.
  assign canIssue  = (state_q == RUN) && (issued_q < n_q) &&
                     (inflight_q < IF_W'(MAX_INFLIGHT));
  assign req_valid = op_valid & canIssue;
  assign op_ready  = req_ready & canIssue;
  assign reqFire   = req_valid & req_ready;

  assign req_function_id = '0;
  assign req_data        = {op_w, op_a};

  // A response arriving with nothing outstanding is a protocol error and is
  // dropped rather than accumulated.
  assign respFire   = resp_valid & resp_ready_q;
  assign respAccept = respFire && (inflight_q != '0);
  assign popCount   = resp_data[PC_W-1:0];

  assign unusedRespBits = ^resp_data[CFU_RESP_DATA_W-1:PC_W];

  assign busy       = busy_q;
  assign done       = done_q;
  assign result     = result_q;
  assign dot        = dot_q;
  assign resp_ready = resp_ready_q;

  // Next-state logic for the sequencer, counters, accumulator and the
  // registered status outputs. Completion is decided on next-count values so
  // the minimum start-to-done latency is three cycles.
  always_comb begin
    state_d      = state_q;
    n_d          = n_q;
    issued_d     = issued_q;
    received_d   = received_q;
    inflight_d   = inflight_q;
    result_d     = result_q;
    dot_d        = dot_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    resp_ready_d = resp_ready_q;
    twiceResult  = '0;
    bitTotal     = '0;
    dotWide      = '0;

    case (state_q)
      IDLE: begin
        if (start) begin
          n_d        = n_words;
          issued_d   = '0;
          received_d = '0;
          inflight_d = '0;
          result_d   = '0;
          dot_d      = '0;
          if (n_words == '0) begin
            state_d = DONE;
          end else begin
            state_d      = RUN;
            busy_d       = 1'b1;
            resp_ready_d = 1'b1;
          end
        end
      end

      RUN, DRAIN: begin
        if (reqFire) begin
          issued_d = issued_q + NW'(1);
        end
        if (respAccept) begin
          received_d = received_q + NW'(1);
          result_d   = result_q + ACC_W'(popCount);
        end
        case ({reqFire, respAccept})
          2'b10:   inflight_d = inflight_q + IF_W'(1);
          2'b01:   inflight_d = inflight_q - IF_W'(1);
          default: inflight_d = inflight_q;
        endcase

        if (state_q == RUN) begin
          if (issued_d == n_q) begin
            state_d = (received_d == n_q) ? DONE : DRAIN;
          end
        end else if (received_d == n_q) begin
          state_d = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // On entry to DONE, publish the signed dot product 2*matches - totalBits.
    if ((state_d == DONE) && (state_q != DONE)) begin
      done_d       = 1'b1;
      busy_d       = 1'b0;
      resp_ready_d = 1'b0;
      twiceResult  = {1'b0, result_d, 1'b0};
      bitTotal     = (ACC_W+2)'(n_d) * (ACC_W+2)'(CFU_REQ_DATA_W);
      dotWide      = twiceResult - bitTotal;
      dot_d        = dotWide[ACC_W:0];
    end
  end

  // State and datapath registers with synchronous active-high reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      n_q          <= '0;
      issued_q     <= '0;
      received_q   <= '0;
      inflight_q   <= '0;
      result_q     <= '0;
      dot_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      resp_ready_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      n_q          <= n_d;
      issued_q     <= issued_d;
      received_q   <= received_d;
      inflight_q   <= inflight_d;
      result_q     <= result_d;
      dot_q        <= dot_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      resp_ready_q <= resp_ready_d;
    end
  end

endmodule
